// File: rtl/ctrl_pkg.sv
// Shared types and register map for the I2S APB register interface.
// Holds the control word layout, register offsets and STATUS bit positions.
// Pure declarations; no logic.
package ctrl_pkg;

   // Control word handed to the I2S serial core
   typedef struct packed {
      logic [15:0] clk_div;   // serial clock divider
      logic [7:0]  ws_len;    // word-select half period in bit clocks
      logic [4:0]  res_bits;  // sample resolution minus one
      logic        mono;      // single-channel mode
      logic        master;    // drive sck/ws from this side
      logic        tran_en;   // transfer enable
   } OP_t;

   // Byte offsets inside the 16-byte register window
   localparam logic [3:0] REG_CTRL   = 4'h0;
   localparam logic [3:0] REG_TXDATA = 4'h4;
   localparam logic [3:0] REG_RXDATA = 4'h8;
   localparam logic [3:0] REG_STATUS = 4'hC;

   // STATUS bit positions
   localparam int ST_TX_EMPTY   = 0;
   localparam int ST_TX_FULL    = 1;
   localparam int ST_RX_EMPTY   = 2;
   localparam int ST_RX_FULL    = 3;
   localparam int ST_TX_OVF     = 4;
   localparam int ST_RX_OVF     = 5;
   localparam int ST_RX_UDF     = 6;
   localparam int ST_TX_CNT_LSB = 8;
   localparam int ST_RX_CNT_LSB = 16;
   localparam int ST_TX_FLUSH   = 24;
   localparam int ST_RX_FLUSH   = 25;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and synchronous flush.
// Latency: a push at edge N is visible on head_dat/empty in cycle N+1.
// Backpressure: push while full and pop while empty are ignored; flush wins over both.
module sync_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output logic [DW-1:0]            head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   // Full/empty come from the pre-edge count, so a push to a full FIFO is
   // dropped even when a pop happens in the same cycle.
   assign full     = (r_cnt == CW'(DEPTH));
   assign empty    = (r_cnt == '0);
   assign count    = r_cnt;
   assign head_dat = r_mem[r_rp];
   assign w_push   = push & ~full;
   assign w_pop    = pop & ~empty;

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Sample storage; contents survive reset, only pointers are cleared
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= push_dat;
   end

endmodule

// File: rtl/i2s_apb_regif.sv
// APB register window for one I2S channel: CTRL word, TX/RX sample FIFOs, sticky status.
// Latency: accesses take effect at the sampling edge; prdata is registered at that edge.
// Backpressure: none on APB (no wait states); full/empty drop writes/reads and set sticky flags.
module i2s_apb_regif
   import ctrl_pkg::*;
#(
   parameter logic [31:0] ADR_OFFSET = 32'h0,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output OP_t         OP,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   output logic        tx_empty,
   output logic        rx_full
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   OP_t           r_op;
   logic [31:0]   r_prdata;
   logic          r_tx_ovf;
   logic          r_rx_ovf;
   logic          r_rx_udf;

   logic          w_sel;
   logic          w_wr;
   logic          w_rd;
   logic [3:0]    w_off;
   logic          w_st_wr;
   logic [31:0]   w_clr;
   logic          w_tx_push;
   logic          w_tx_full;
   logic          w_tx_flush;
   logic [CW-1:0] w_tx_cnt;
   logic          w_rx_pop;
   logic          w_rx_empty;
   logic          w_rx_flush;
   logic [CW-1:0] w_rx_cnt;
   logic [31:0]   w_rx_head;
   logic [31:0]   w_status;

   assign w_sel      = penable & (paddr[31:4] == ADR_OFFSET[31:4]);
   assign w_off      = paddr[3:0];
   assign w_wr       = w_sel & pwrite;
   assign w_rd       = w_sel & ~pwrite;
   assign w_st_wr    = w_wr & (w_off == REG_STATUS);
   assign w_clr      = w_st_wr ? pwdata : 32'h0;
   assign w_tx_push  = w_wr & (w_off == REG_TXDATA);
   assign w_tx_flush = w_clr[ST_TX_FLUSH];
   assign w_rx_pop   = w_rd & (w_off == REG_RXDATA);
   assign w_rx_flush = w_clr[ST_RX_FLUSH];

   assign tx_valid = ~tx_empty;
   assign OP       = r_op;
   assign prdata   = r_prdata;

   sync_fifo #(.DW(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(pclk), .rst_n(preset),
      .push(w_tx_push), .push_dat(pwdata),
      .pop(tx_ready), .flush(w_tx_flush),
      .head_dat(tx_data), .full(w_tx_full), .empty(tx_empty), .count(w_tx_cnt)
   );

   sync_fifo #(.DW(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(pclk), .rst_n(preset),
      .push(rx_valid), .push_dat(rx_data),
      .pop(w_rx_pop), .flush(w_rx_flush),
      .head_dat(w_rx_head), .full(rx_full), .empty(w_rx_empty), .count(w_rx_cnt)
   );

   // STATUS read image built from pre-edge FIFO and sticky state
   always_comb begin
      w_status                           = 32'h0;
      w_status[ST_TX_EMPTY]              = tx_empty;
      w_status[ST_TX_FULL]               = w_tx_full;
      w_status[ST_RX_EMPTY]              = w_rx_empty;
      w_status[ST_RX_FULL]               = rx_full;
      w_status[ST_TX_OVF]                = r_tx_ovf;
      w_status[ST_RX_OVF]                = r_rx_ovf;
      w_status[ST_RX_UDF]                = r_rx_udf;
      w_status[ST_TX_CNT_LSB +: 8]       = 8'(w_tx_cnt);
      w_status[ST_RX_CNT_LSB +: 8]       = 8'(w_rx_cnt);
   end

   // CTRL register
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset)                             r_op <= '0;
      else if (w_wr && (w_off == REG_CTRL))    r_op <= OP_t'(pwdata);
   end

   // Sticky error flags: a set in the same cycle as a W1C clear wins
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         r_tx_ovf <= 1'b0;
         r_rx_ovf <= 1'b0;
         r_rx_udf <= 1'b0;
      end else begin
         r_tx_ovf <= (w_tx_push & w_tx_full)  | (r_tx_ovf & ~w_clr[ST_TX_OVF]);
         r_rx_ovf <= (rx_valid & rx_full)     | (r_rx_ovf & ~w_clr[ST_RX_OVF]);
         r_rx_udf <= (w_rx_pop & w_rx_empty)  | (r_rx_udf & ~w_clr[ST_RX_UDF]);
      end
   end

   // Read data register; unmapped offsets keep the previous value
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         r_prdata <= 32'h0;
      end else if (w_rd) begin
         case (w_off)
            REG_CTRL:   r_prdata <= r_op;
            REG_TXDATA: r_prdata <= 32'h0;
            REG_RXDATA: r_prdata <= w_rx_empty ? 32'h0 : w_rx_head;
            REG_STATUS: r_prdata <= w_status;
            default:    r_prdata <= r_prdata;
         endcase
      end
   end

endmodule
